// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load/ready and serial valid/last signals between the PISO and its neighbours.
// The master drives load and shift strobes; the slave (the serializer) drives ready and the serial stream.
interface piso_serializer_if #(
    parameter int N = 4
);
    logic         i_load;
    logic [N-1:0] i_parallel_in;
    logic         i_shift_en;
    logic         o_ready;
    logic         o_serial_out;
    logic         o_serial_valid;
    logic         o_last;

    modport master (
        output i_load, i_parallel_in, i_shift_en,
        input  o_ready, o_serial_out, o_serial_valid, o_last
    );

    modport slave (
        input  i_load, i_parallel_in, i_shift_en,
        output o_ready, o_serial_out, o_serial_valid, o_last
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with load/ready handshake and valid/last qualifiers.
// Optional even-parity trailer bit is compiled in with PISO_PARITY_EN.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              i_clk,
    input logic              i_rst,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(N + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t          r_state, w_next_state;
    logic [N-1:0]    r_shreg, w_next_shreg;
    logic [CW-1:0]   r_cnt, w_next_cnt;
    logic            w_last_bit;
    logic            w_data_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_shreg <= w_next_shreg;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_shreg = r_shreg;
        w_next_cnt   = r_cnt;
        w_last_bit   = (r_cnt == CW'(1));
        case (r_state)
            IDLE: begin
                if (bus.i_load) begin
                    w_next_shreg = bus.i_parallel_in;
                    w_next_cnt   = CW'(N);
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.i_shift_en) begin
                    w_next_shreg = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
                    w_next_cnt   = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
`ifdef PISO_PARITY_EN
                    w_next_state = w_last_bit ? PARITY : SHIFT;
`else
                    w_next_state = w_last_bit ? IDLE : SHIFT;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: w_next_state = bus.i_shift_en ? IDLE : PARITY;
`endif
            default: w_next_state = IDLE;
        endcase
    end

    assign w_data_bit = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];

`ifdef PISO_PARITY_EN
    logic r_par;

    // Parity is captured from the loaded word so it survives the shifting that empties r_shreg.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_par <= 1'b0;
        else if (r_state == IDLE && bus.i_load)
            r_par <= ^bus.i_parallel_in;
    end

    assign bus.o_serial_out = (r_state == SHIFT) ? w_data_bit : (r_state == PARITY) ? r_par : 1'b0;
    assign bus.o_last       = (r_state == PARITY);
`else
    assign bus.o_serial_out = (r_state == SHIFT) ? w_data_bit : 1'b0;
    assign bus.o_last       = (r_state == SHIFT) && w_last_bit;
`endif

    assign bus.o_ready        = (r_state == IDLE);
    assign bus.o_serial_valid = (r_state != IDLE);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving an MSB-first and an LSB-first serializer in lockstep.
// Expected bits are queued when a load is accepted and popped as each bit is consumed.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       shift_en = 1'b0;
    logic [3:0] pin = 4'b0000;
    int         checks = 0;
    int         failures = 0;
    logic       q_m[$];
    logic       q_l[$];

    piso_serializer_if #(.N(4)) bus_m ();
    piso_serializer_if #(.N(4)) bus_l ();

    assign bus_m.i_load = load;
    assign bus_m.i_parallel_in = pin;
    assign bus_m.i_shift_en = shift_en;
    assign bus_l.i_load = load;
    assign bus_l.i_parallel_in = pin;
    assign bus_l.i_shift_en = shift_en;

    piso_serializer #(.N(4), .MSB_FIRST(1'b1)) dut_m (.i_clk(clk), .i_rst(rst), .bus(bus_m));
    piso_serializer #(.N(4), .MSB_FIRST(1'b0)) dut_l (.i_clk(clk), .i_rst(rst), .bus(bus_l));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < 4; i++) q_l.push_back(w[i]);
`ifdef PISO_PARITY_EN
        q_m.push_back(^w);
        q_l.push_back(^w);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, bus_m.o_ready, 1'b1);
        chk({tag, "_valid"}, bus_m.o_serial_valid, 1'b0);
        chk({tag, "_out"}, bus_m.o_serial_out, 1'b0);
        chk({tag, "_last"}, bus_m.o_last, 1'b0);
        chk({tag, "_ready_l"}, bus_l.o_ready, 1'b1);
        chk({tag, "_valid_l"}, bus_l.o_serial_valid, 1'b0);
    endtask

    // Sample half a cycle away from the active edge; the popped bit is the one the next edge consumes.
    always @(negedge clk) begin
        logic er;
        if (rst) begin
            chk_reset("rst");
            q_m.delete();
            q_l.delete();
        end else begin
            er = (q_m.size() == 0);
            chk("ready_m", bus_m.o_ready, er);
            chk("ready_l", bus_l.o_ready, er);
            chk("valid_m", bus_m.o_serial_valid, !er);
            chk("valid_l", bus_l.o_serial_valid, !er);
            if (er) begin
                chk("idle_out_m", bus_m.o_serial_out, 1'b0);
                chk("idle_last_m", bus_m.o_last, 1'b0);
            end else begin
                chk("bit_m", bus_m.o_serial_out, q_m[0]);
                chk("bit_l", bus_l.o_serial_out, q_l[0]);
                chk("last_m", bus_m.o_last, q_m.size() == 1);
                chk("last_l", bus_l.o_last, q_l.size() == 1);
                if (shift_en) begin
                    void'(q_m.pop_front());
                    void'(q_l.pop_front());
                end
            end
            if (er && load) push(pin);
        end
    end

    initial begin
        // Reset held with a pending load: nothing may be captured.
        load = 1'b1;
        pin = 4'b1010;
        repeat (3) step();
        rst = 1'b0;
        load = 1'b0;
        step();
        // Basic frame, continuous consumption.
        load = 1'b1;
        pin = 4'b1010;
        shift_en = 1'b1;
        step();
        load = 1'b0;
        repeat (7) step();
        // Stalled shifting.
        load = 1'b1;
        pin = 4'b0101;
        shift_en = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            shift_en = i[0];
            step();
        end
        shift_en = 1'b1;
        repeat (2) step();
        // Load during the second bit is ignored.
        load = 1'b1;
        pin = 4'b1100;
        step();
        load = 1'b0;
        step();
        load = 1'b1;
        pin = 4'b1111;
        step();
        load = 1'b0;
        repeat (6) step();
        // Asynchronous reset mid-frame, then a load on the first edge after release.
        load = 1'b1;
        pin = 4'b1010;
        step();
        load = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1 chk_reset("async");
        step();
        rst = 1'b0;
        load = 1'b1;
        pin = 4'b0110;
        step();
        load = 1'b0;
        repeat (7) step();
        // Load held high: exactly one idle cycle separates frames.
        load = 1'b1;
        pin = 4'b1001;
        repeat (12) step();
        load = 1'b0;
        pin = 4'b1011;
        repeat (7) step();
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (7) step();
        // Random loads, words and consume strobes.
        for (int i = 0; i < 80; i++) begin
            load = 1'($urandom_range(0, 1));
            pin = 4'($urandom);
            shift_en = 1'($urandom_range(0, 1));
            step();
        end
        load = 1'b0;
        shift_en = 1'b1;
        repeat (8) step();
        chk("drained_m", q_m.size() == 0, 1'b1);
        chk("drained_l", q_l.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly downstream of the 4-bit PIPO holding register. It accepts a parallel word through a load/ready handshake and shifts it out one bit per enabled cycle with a valid/last qualifier. It converts the PIPO's `o_parallel_out` into a serial stream for the link layer.

## Interface
- `N`, default 4: data word width; must be ≥ 2.
- `MSB_FIRST`, default 1:
  - 1 shifts bit `N-1` first.
  - 0 shifts bit 0 first.
- `i_clk`  in  1: single clock; all state updates on its rising edge.
- `i_rst`  in  1: reset, asynchronous and active-high.
- `i_load`  in  1: load request; captures `i_parallel_in` when `o_ready`=1.
- `i_parallel_in`  in  N: word to serialize, normally the PIPO's `o_parallel_out`.
- `i_shift_en`  in  1: downstream consume strobe; the presented bit is consumed on any edge where it is 1 while `o_serial_valid`=1.
- `o_ready`  out  1: 1 only in IDLE; the block accepts a load this cycle.
- `o_serial_out`  out  1: current serial bit.
- `o_serial_valid`  out  1: `o_serial_out` holds a frame bit.
- `o_last`  out  1: the presented bit is the final bit of the frame.

## Operation
- **States:** IDLE, SHIFT, and PARITY (PARITY exists only with the macro; see Configuration).
- **IDLE**
  - `o_ready`=1 and `o_serial_valid`=0.
  - On an edge with `i_load`=1: the shift register takes `i_parallel_in`, bit counter ← N, state → SHIFT.
- **SHIFT**
  - `o_serial_out` = shift-register MSB when `MSB_FIRST`=1, LSB otherwise.
  - `o_serial_valid`=1.
  - On an edge with `i_shift_en`=1: the register shifts by one toward the output end, filling with 0, and the counter decrements.
  - When the counter is 1 and `i_shift_en`=1, the next state is IDLE, or PARITY if that state is compiled in.
  - With `i_shift_en`=0, the bit and all state hold indefinitely.
- **Ignored loads:** `i_load` in SHIFT or PARITY is ignored. The in-flight word is never corrupted and the new word is never queued.
- **Output source:** all outputs decode from registers only. There is no combinational path from any input to any output.
- **Counter width:** `$clog2(N+1)` bits; it never wraps below 0.
- **Reset values** (asynchronous; apply immediately on `i_rst`=1, including mid-frame):
  - state = IDLE, shift register = 0, counter = 0.
  - `o_ready`=1, `o_serial_out`=0, `o_serial_valid`=0, `o_last`=0.
  - A frame in progress at reset is discarded; no partial frame resumes.

## Timing
- **Load latency:** `i_load` sampled at edge k → first bit on `o_serial_out`, with `o_serial_valid`=1 and `o_ready`=0, from just after edge k.
- **Bit duration:** each bit is held from the edge after it appears until the first edge with `i_shift_en`=1.
- **Frame end:**
  - `o_last`=1 exactly while the final frame bit is presented.
  - IDLE, with `o_ready`=1, is reached after the edge that consumes that bit.
- **Throughput:** with `i_shift_en` held at 1, one word needs N cycles (N+1 with parity) plus 1 IDLE cycle before the next load is accepted. There is no back-to-back loading.
- **Reset release:** `i_load`=1 on the first edge after `i_rst` deasserts is accepted.

## Configuration
- **Macro:** `PISO_PARITY_EN`.
- **When defined:**
  - At load, even parity (XOR of all N bits of `i_parallel_in`) is stored.
  - After the last data bit is consumed, the state moves to PARITY and presents the parity bit with `o_serial_valid`=1 and `o_last`=1.
  - Consuming the parity bit returns to IDLE.
  - Frame length is N+1 bits.
  - In this build `o_last` is never 1 during SHIFT.
- **When undefined:**
  - The PARITY state and parity register do not exist.
  - Frame length is N bits, and `o_last` marks data bit N.

## Test plan
1. **Reset:** hold `i_rst`=1 for 3 cycles with `i_load`=1 and `i_parallel_in`=4'b1010 → `o_ready`=1, `o_serial_valid`=0, `o_serial_out`=0 throughout, and no load is taken.
2. **Basic frame:** `N`=4, `MSB_FIRST`=1, load 4'b1010, `i_shift_en`=1 constantly → bits 1,0,1,0 on the 4 cycles after the load edge; `o_last` on the 4th; `o_ready`=1 on the 5th. With `MSB_FIRST`=0 the same load yields 0,1,0,1.
3. **Stalled shifting:** load 4'b0101 with `i_shift_en` alternating 1,0 → each bit is held 2 cycles and the frame spans 8 cycles with an unchanged bit order.
4. **Ignored load:** load 4'b1100, then assert `i_load` with 4'b1111 during the 2nd bit → the output remains 1,1,0,0 and `o_ready` stays 0 until the frame ends.
5. **Reset mid-frame:** assert `i_rst` asynchronously after 2 bits of 4'b1010 → outputs go to reset values before the next edge. A subsequent load of 4'b0110 emits 0,1,1,0.
6. **Parity build:** with `PISO_PARITY_EN` defined, load 4'b1011 → 1,0,1,1 then parity bit 1 with `o_last`=1. Load 4'b0110 → 0,1,1,0 then parity bit 0.
